// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
`timescale 1ns/1ps
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Starvation counter width; MAX_WAIT must fit (1..15).
  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Saturating count of consecutive cycles the long-latency unit has been blocked.
`timescale 1ns/1ps
module rf_arb_starve_ctr
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit,
  output logic last
);

  localparam logic [ARB_CNT_W-1:0] W_MAX = ARB_CNT_W'(MAX_WAIT);
  localparam logic [ARB_CNT_W-1:0] W_ONE = ARB_CNT_W'(1);

  logic [ARB_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != W_MAX)) begin
      r_count <= r_count + W_ONE;
    end
  end

  assign hit  = (r_count == W_MAX);
  // True when one more blocked cycle reaches the limit.
  assign last = ((r_count + W_ONE) == W_MAX);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and the long-latency unit.
// Optional build macro RF_ARB_STATS_EN adds the force_cnt statistics output.
`timescale 1ns/1ps
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              stall_wb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]       force_cnt
`endif
);

  localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(REG_ZERO);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic              w_wb_req;
  logic              w_lu_req;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic              w_cnt_hit;
  logic              w_cnt_last;
  logic              w_grant_wb;
  logic              w_grant_lu;
  logic              w_lu_ready;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  // Writes to $0 are architecturally discarded, so they never compete for the port.
  assign w_wb_req = wb_we && (wb_addr != W_ZERO);
  assign w_lu_req = lu_valid && (lu_addr != W_ZERO);

  rf_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_cnt_inc),
    .clr  (w_cnt_clr),
    .hit  (w_cnt_hit),
    .last (w_cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_wb_req && lu_valid) begin
          w_cnt_inc    = 1'b1;
          w_state_next = (MAX_WAIT == 1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (!lu_valid) begin
          w_cnt_clr    = 1'b1;
          w_state_next = IDLE;
        end else if (w_wb_req) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last || w_cnt_hit) begin
            w_state_next = FORCE;
          end
        end else begin
          w_cnt_clr    = 1'b1;
          w_state_next = IDLE;
        end
      end
      FORCE: begin
        w_cnt_clr    = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_grant_wb = 1'b0;
    w_grant_lu = 1'b0;
    w_lu_ready = 1'b0;
    case (r_state)
      IDLE, WAIT: begin
        if (w_wb_req) begin
          w_grant_wb = 1'b1;
        end else if (lu_valid) begin
          w_lu_ready = 1'b1;
          w_grant_lu = w_lu_req;
        end
      end
      FORCE: begin
        // Writeback is frozen by stall_wb and re-presents its write next cycle.
        w_lu_ready = 1'b1;
        w_grant_lu = w_lu_req;
      end
      default: begin
        w_lu_ready = 1'b0;
      end
    endcase
  end

  assign lu_ready = w_lu_ready && !rst;
  assign stall_wb = (r_state == FORCE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= w_grant_wb || w_grant_lu;
      if (w_grant_wb) begin
        r_rf_addr <= wb_addr;
        r_rf_data <= wb_data;
      end else if (w_grant_lu) begin
        r_rf_addr <= lu_addr;
        r_rf_data <= lu_data;
      end
    end
  end

  assign rf_we   = r_rf_we;
  assign rf_addr = r_rf_addr;
  assign rf_data = r_rf_data;

`ifdef RF_ARB_STATS_EN
  logic [15:0] r_force_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_force_cnt <= '0;
    end else if ((w_state_next == FORCE) && (r_state != FORCE) && (r_force_cnt != 16'hFFFF)) begin
      r_force_cnt <= r_force_cnt + 16'd1;
    end
  end

  assign force_cnt = r_force_cnt;
`endif

endmodule
